// File: rtl/xm_pkg.sv
// Shared definitions for the register file, the instruction decoder and the
// write-back selector: register indices, address width, step constants and
// the update-source enumeration.
package xm_pkg;

  localparam int REG_COUNT_DEF = 8;
  localparam int REG_ADDR_W    = $clog2(REG_COUNT_DEF);
  localparam int PC_IDX        = 7;
  localparam int SP_IDX        = 6;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam int STEP_WORD = 2;
  localparam int STEP_BYTE = 1;

  // Update sources in descending priority order.
  typedef enum logic [1:0] {
    WB_SRC  = 2'd0,
    MOD_SRC = 2'd1,
    PCI_SRC = 2'd2
  } upd_src_e;

endpackage

// File: rtl/reg_step_unit.sv
// Combinational +/-1 / +/-2 adder, wrapping modulo 2^WORD_SIZE.
// Ports:
//   val_i   operand
//   dec_i   1 = subtract step, 0 = add step
//   byte_i  1 = step 1, 0 = step 2
//   res_o   stepped result
module reg_step_unit
  import xm_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic [WORD_SIZE-1:0] val_i,
  input  logic                 dec_i,
  input  logic                 byte_i,
  output logic [WORD_SIZE-1:0] res_o
);

  logic [WORD_SIZE-1:0] step;

  assign step  = byte_i ? WORD_SIZE'(STEP_BYTE) : WORD_SIZE'(STEP_WORD);
  assign res_o = dec_i ? (val_i - step) : (val_i + step);

endmodule

// File: rtl/register_file.sv
// Architectural register file R0..R7 (R7 = PC).
// Two combinational read ports, three update paths with per-register
// priority write-back > modify > PC increment.
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   wb_en_i/wb_byte_i       write-back strobe / low-byte-only write
//   wb_addr_i/wb_data_i     write-back target and data
//   mod_en_i/mod_dec_i      modify strobe / decrement select
//   mod_byte_i/mod_addr_i   step size (1 = step 1) / register to modify
//   pc_inc_i                advance R7 by 2
//   rd_a_*, rd_b_*          read ports
//   pc_out_o                current R7
module register_file
  import xm_pkg::*;
#(
  parameter int                   WORD_SIZE = 16,
  parameter int                   REG_COUNT = 8,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wb_en_i,
  input  logic                         wb_byte_i,
  input  logic [$clog2(REG_COUNT)-1:0] wb_addr_i,
  input  logic [WORD_SIZE-1:0]         wb_data_i,
  input  logic                         mod_en_i,
  input  logic                         mod_dec_i,
  input  logic                         mod_byte_i,
  input  logic [$clog2(REG_COUNT)-1:0] mod_addr_i,
  input  logic                         pc_inc_i,
  input  logic [$clog2(REG_COUNT)-1:0] rd_a_addr_i,
  input  logic [$clog2(REG_COUNT)-1:0] rd_b_addr_i,
  output logic [WORD_SIZE-1:0]         rd_a_data_o,
  output logic [WORD_SIZE-1:0]         rd_b_data_o,
  output logic [WORD_SIZE-1:0]         pc_out_o
);

  localparam int AW = $clog2(REG_COUNT);

  logic [REG_COUNT-1:0][WORD_SIZE-1:0] regs_q, regs_d;
  logic [WORD_SIZE-1:0]                mod_res, pc_res;
  logic [2:0]                          hit;

  // Only one register can be modified per cycle, so a single stepper
  // serves the modify path; a second one produces PC + 2.
  reg_step_unit #(.WORD_SIZE(WORD_SIZE)) u_mod_step (
    .val_i  (regs_q[mod_addr_i]),
    .dec_i  (mod_dec_i),
    .byte_i (mod_byte_i),
    .res_o  (mod_res)
  );

  reg_step_unit #(.WORD_SIZE(WORD_SIZE)) u_pc_step (
    .val_i  (regs_q[PC_IDX]),
    .dec_i  (1'b0),
    .byte_i (1'b0),
    .res_o  (pc_res)
  );

  always_comb begin
    regs_d = regs_q;
    hit    = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      hit[WB_SRC]  = wb_en_i  && (wb_addr_i  == AW'(r));
      hit[MOD_SRC] = mod_en_i && (mod_addr_i == AW'(r));
      hit[PCI_SRC] = pc_inc_i && (r == PC_IDX);
      if (hit[WB_SRC]) begin
        // Byte write wins outright: upper byte keeps its pre-edge value,
        // any concurrent modify step is dropped.
        if (wb_byte_i) regs_d[r][7:0] = wb_data_i[7:0];
        else           regs_d[r]      = wb_data_i;
      end else if (hit[MOD_SRC]) begin
        regs_d[r] = mod_res;
      end else if (hit[PCI_SRC]) begin
        regs_d[r] = pc_res;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      regs_q         <= '0;
      regs_q[PC_IDX] <= RESET_PC;
    end else begin
      regs_q <= regs_d;
    end
  end

  // No bypass: reads see only committed contents.
  assign rd_a_data_o = regs_q[rd_a_addr_i];
  assign rd_b_data_o = regs_q[rd_b_addr_i];
  assign pc_out_o    = regs_q[PC_IDX];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, hand-written
// reset and read-timing sequences, and randomized traffic against a
// behavioural model.
module tb_register_file;

  localparam logic [15:0] RPC = 16'h0100;

  logic        clk, rst;
  logic        wb_en, wb_byte, mod_en, mod_dec, mod_byte, pc_inc;
  logic [2:0]  wb_addr, mod_addr, rd_a_addr, rd_b_addr;
  logic [15:0] wb_data, rd_a_data, rd_b_data, pc_out;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [8];

  register_file #(.WORD_SIZE(16), .REG_COUNT(8), .RESET_PC(RPC)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wb_en_i     (wb_en),
    .wb_byte_i   (wb_byte),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
    .mod_en_i    (mod_en),
    .mod_dec_i   (mod_dec),
    .mod_byte_i  (mod_byte),
    .mod_addr_i  (mod_addr),
    .pc_inc_i    (pc_inc),
    .rd_a_addr_i (rd_a_addr),
    .rd_b_addr_i (rd_b_addr),
    .rd_a_data_o (rd_a_data),
    .rd_b_data_o (rd_b_data),
    .pc_out_o    (pc_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic        wb_en, wb_byte;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        mod_en, mod_dec, mod_byte;
    logic [2:0]  mod_addr;
    logic        pc_inc;
    logic [2:0]  chk_addr;
    logic [15:0] exp;
  } vec_t;

  function automatic vec_t mkv(logic we, logic wbb, logic [2:0] wa, logic [15:0] wd,
                               logic me, logic md, logic mb, logic [2:0] ma,
                               logic pi, logic [2:0] ca, logic [15:0] ex);
    vec_t v;
    v.wb_en = we; v.wb_byte = wbb; v.wb_addr = wa; v.wb_data = wd;
    v.mod_en = me; v.mod_dec = md; v.mod_byte = mb; v.mod_addr = ma;
    v.pc_inc = pi; v.chk_addr = ca; v.exp = ex;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: apply lower-priority paths first, later ones overwrite.
  task automatic model_step();
    logic [15:0] nxt [8];
    int step;
    for (int i = 0; i < 8; i++) nxt[i] = model[i];
    if (pc_inc) nxt[7] = model[7] + 16'd2;
    if (mod_en) begin
      step = mod_byte ? 1 : 2;
      nxt[mod_addr] = mod_dec ? model[mod_addr] - 16'(step) : model[mod_addr] + 16'(step);
    end
    if (wb_en)
      nxt[wb_addr] = wb_byte ? {model[wb_addr][15:8], wb_data[7:0]} : wb_data;
    for (int i = 0; i < 8; i++) model[i] = nxt[i];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 7; i++) model[i] = 16'h0000;
    model[7] = RPC;
  endtask

  task automatic idle_inputs();
    wb_en = 0; wb_byte = 0; wb_addr = 0; wb_data = 0;
    mod_en = 0; mod_dec = 0; mod_byte = 0; mod_addr = 0; pc_inc = 0;
  endtask

  // Sweeps every register through read port B (takes 8 time units).
  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_b_addr = 3'(i);
      #1;
      check({tag, "_reg", $sformatf("%0d", i)}, rd_b_data, model[i]);
    end
    check({tag, "_pc"}, pc_out, model[7]);
  endtask

  // Inputs already driven; clock one edge, update model, drop strobes.
  task automatic clock_edge();
    model_step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  vec_t vecs [18];

  initial begin
    idle_inputs();
    rd_a_addr = 0; rd_b_addr = 0;
    rst = 1'b1;
    model_reset();
    #3;
    check_all("reset_init");
    @(negedge clk);
    rst = 1'b0;

    vecs[0]  = mkv(1,0,3,16'hABCD, 0,0,0,0, 0, 3,16'hABCD);
    vecs[1]  = mkv(1,1,3,16'h1234, 0,0,0,0, 0, 3,16'hAB34);
    vecs[2]  = mkv(1,0,3,16'h1234, 0,0,0,0, 0, 3,16'h1234);
    vecs[3]  = mkv(1,0,5,16'hFFFF, 0,0,0,0, 0, 5,16'hFFFF);
    vecs[4]  = mkv(0,0,0,16'h0000, 1,0,1,5, 0, 5,16'h0000);
    vecs[5]  = mkv(0,0,0,16'h0000, 1,1,0,5, 0, 5,16'hFFFE);
    vecs[6]  = mkv(1,0,7,16'h0200, 0,0,0,0, 1, 7,16'h0200);
    vecs[7]  = mkv(1,0,7,16'h0010, 0,0,0,0, 0, 7,16'h0010);
    vecs[8]  = mkv(0,0,0,16'h0000, 1,1,0,7, 1, 7,16'h000E);
    vecs[9]  = mkv(1,0,7,16'h0010, 0,0,0,0, 0, 7,16'h0010);
    vecs[10] = mkv(0,0,0,16'h0000, 0,0,0,0, 1, 7,16'h0012);
    vecs[11] = mkv(1,0,6,16'h1000, 0,0,0,0, 0, 6,16'h1000);
    vecs[12] = mkv(1,0,7,16'h0020, 0,0,0,0, 0, 7,16'h0020);
    vecs[13] = mkv(1,0,1,16'h5555, 1,0,0,6, 1, 1,16'h5555);
    vecs[14] = mkv(0,0,0,16'h0000, 0,0,0,0, 0, 6,16'h1002);
    vecs[15] = mkv(0,0,0,16'h0000, 0,0,0,0, 0, 7,16'h0022);
    // byte write-back beats a modify on the same register
    vecs[16] = mkv(1,1,6,16'h77AB, 1,0,0,6, 0, 6,16'h10AB);
    // modify on R0 with decrement step 1 from 0 wraps
    vecs[17] = mkv(0,0,0,16'h0000, 1,1,1,0, 0, 0,16'hFFFF);

    for (int k = 0; k < 18; k++) begin
      wb_en = vecs[k].wb_en; wb_byte = vecs[k].wb_byte;
      wb_addr = vecs[k].wb_addr; wb_data = vecs[k].wb_data;
      mod_en = vecs[k].mod_en; mod_dec = vecs[k].mod_dec;
      mod_byte = vecs[k].mod_byte; mod_addr = vecs[k].mod_addr;
      pc_inc = vecs[k].pc_inc;
      rd_a_addr = vecs[k].chk_addr;
      clock_edge();
      check($sformatf("vec%0d", k), rd_a_data, vecs[k].exp);
      check_all($sformatf("vec%0d", k));
    end
    check("disjoint_r6", model[6], 16'h10AB);

    // Read timing: old value before the edge, new value after, no bypass.
    @(negedge clk);
    wb_en = 1; wb_addr = 4; wb_data = 16'h00FF;
    rd_a_addr = 4; rd_b_addr = 4;
    #1;
    check("rd_before_edge", rd_a_data, model[4]);
    check("rd_b_match_before", rd_b_data, rd_a_data);
    clock_edge();
    check("rd_after_edge", rd_a_data, 16'h00FF);
    check("rd_b_match_after", rd_b_data, rd_a_data);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      wb_en    = ($urandom_range(0, 2) == 0);
      wb_byte  = 1'($urandom);
      wb_addr  = 3'($urandom);
      wb_data  = 16'($urandom);
      mod_en   = ($urandom_range(0, 1) == 0);
      mod_dec  = 1'($urandom);
      mod_byte = 1'($urandom);
      mod_addr = 3'($urandom);
      pc_inc   = 1'($urandom);
      rd_a_addr = 3'($urandom);
      clock_edge();
      check("rand_rd_a", rd_a_data, model[rd_a_addr]);
      if (n % 8 == 0) check_all("rand");
    end

    // Async reset mid-cycle with strobes active, checked before any edge.
    @(posedge clk);
    #3;
    wb_en = 1; wb_addr = 2; wb_data = 16'hDEAD; pc_inc = 1;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_pc", pc_out, RPC);
    check_all("async_rst");
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_rst_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
